// File: rtl/mac_bus_initiator.sv
// Initiator for MC68000-style bus cycles on the slow Mac bus, sequenced from synchronized
// C8M/E events on the fast clock and reporting completion as Ready or nBERRMac.
module mac_bus_initiator #(
  parameter int unsigned TIMEOUT = 200
) (
  input  logic FCLK,
  input  logic Reset,
  input  logic Req,
  input  logic RnW,
  input  logic nUDSIn,
  input  logic nLDSIn,
  output logic Ready,
  output logic nBERRMac,
  input  logic C8M,
  input  logic E,
  input  logic nDTACKIn,
  input  logic nVPAIn,
  input  logic nBERRIn,
  output logic nASMac,
  output logic nUDSMac,
  output logic nLDSMac,
  output logic RnWMac,
  output logic nVMA,
  output logic ABEn,
  output logic DBEn,
  output logic DLatch
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StAddr, StStrb, StWait, StVwait, StData, StTerm, StDone
  } state_e;

  typedef enum logic [1:0] {VsWaitLow, VsWaitRise, VsWaitFall} vsub_e;

  state_e          state_q, state_d;
  vsub_e           vsub_q, vsub_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      c8m_q, e_q;
  logic [1:0]      dtack_q, vpa_q, berr_q;
  logic            rnw_lat_q, rnw_lat_d, uds_lat_q, uds_lat_d, lds_lat_q, lds_lat_d;
  logic            err_q, err_d;
  logic            as_q, as_d, uds_q, uds_d, lds_q, lds_d, vma_q, vma_d;
  logic            rnw_mac_q, rnw_mac_d, abe_q, abe_d, dbe_q, dbe_d, dlatch_q, dlatch_d;
  logic            ready_q, ready_d, berr_mac_q, berr_mac_d;

  logic c8m_rise, c8m_fall, e_rise, e_fall, e_s, dtack_s, vpa_s, berr_s;

  assign c8m_rise = c8m_q[1] & ~c8m_q[2];
  assign c8m_fall = ~c8m_q[1] & c8m_q[2];
  assign e_rise   = e_q[1] & ~e_q[2];
  assign e_fall   = ~e_q[1] & e_q[2];
  assign e_s      = e_q[1];
  assign dtack_s  = dtack_q[1];
  assign vpa_s    = vpa_q[1];
  assign berr_s   = berr_q[1];

  always_comb begin
    state_d    = state_q;
    vsub_d     = vsub_q;
    cnt_d      = cnt_q;
    rnw_lat_d  = rnw_lat_q;
    uds_lat_d  = uds_lat_q;
    lds_lat_d  = lds_lat_q;
    err_d      = err_q;
    as_d       = as_q;
    uds_d      = uds_q;
    lds_d      = lds_q;
    vma_d      = vma_q;
    rnw_mac_d  = rnw_mac_q;
    abe_d      = abe_q;
    dbe_d      = dbe_q;
    dlatch_d   = 1'b0;
    ready_d    = ready_q;
    berr_mac_d = berr_mac_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (Req && c8m_rise) begin
          state_d   = StAddr;
          rnw_lat_d = RnW;
          uds_lat_d = nUDSIn;
          lds_lat_d = nLDSIn;
          abe_d     = 1'b1;
          rnw_mac_d = RnW;
        end
      end
      StAddr: begin
        if (c8m_fall) begin
          state_d = StStrb;
          as_d    = 1'b0;
          if (rnw_lat_q) begin
            uds_d = uds_lat_q;
            lds_d = lds_lat_q;
          end
        end
      end
      StStrb: begin
        if (c8m_rise) begin
          state_d = StWait;
          if (!rnw_lat_q) begin
            dbe_d = 1'b1;
            uds_d = uds_lat_q;
            lds_d = lds_lat_q;
          end
        end
      end
      StWait: begin
        if (c8m_fall) begin
          if (!berr_s) begin
            state_d = StTerm;
            err_d   = 1'b1;
          end else if (!dtack_s) begin
            state_d = StData;
          end else if (!vpa_s) begin
            state_d = StVwait;
            vsub_d  = VsWaitLow;
          end else if (cnt_q == CntLast) begin
            state_d = StTerm;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StVwait: begin
        if (c8m_fall && !berr_s) begin
          state_d = StTerm;
          err_d   = 1'b1;
        end else if (c8m_fall && (cnt_q == CntLast)) begin
          state_d = StTerm;
          err_d   = 1'b1;
        end else begin
          if (c8m_fall) cnt_d = cnt_q + CntW'(1);
          // E phase walk: synchronized E low, then one full E high pulse
          unique case (vsub_q)
            VsWaitLow: begin
              if (!e_s) begin
                vma_d  = 1'b0;
                vsub_d = VsWaitRise;
              end
            end
            VsWaitRise: if (e_rise) vsub_d = VsWaitFall;
            VsWaitFall: if (e_fall) state_d = StData;
            default:    vsub_d = VsWaitLow;
          endcase
        end
      end
      StData: begin
        if (c8m_rise) begin
          state_d  = StTerm;
          dlatch_d = rnw_lat_q;
        end
      end
      StTerm: begin
        if (c8m_fall) begin
          as_d  = 1'b1;
          uds_d = 1'b1;
          lds_d = 1'b1;
          vma_d = 1'b1;
          dbe_d = 1'b0;
          if (Req) begin
            state_d = StDone;
            if (err_q) berr_mac_d = 1'b0;
            else       ready_d    = 1'b1;
          end else begin
            state_d   = StIdle;
            abe_d     = 1'b0;
            rnw_mac_d = 1'b1;
            err_d     = 1'b0;
          end
        end
      end
      StDone: begin
        if (!Req) begin
          state_d    = StIdle;
          ready_d    = 1'b0;
          berr_mac_d = 1'b1;
          abe_d      = 1'b0;
          rnw_mac_d  = 1'b1;
          err_d      = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge FCLK) begin
    if (Reset) begin
      c8m_q      <= 3'b000;
      e_q        <= 3'b000;
      dtack_q    <= 2'b11;
      vpa_q      <= 2'b11;
      berr_q     <= 2'b11;
      state_q    <= StIdle;
      vsub_q     <= VsWaitLow;
      cnt_q      <= '0;
      rnw_lat_q  <= 1'b1;
      uds_lat_q  <= 1'b1;
      lds_lat_q  <= 1'b1;
      err_q      <= 1'b0;
      as_q       <= 1'b1;
      uds_q      <= 1'b1;
      lds_q      <= 1'b1;
      vma_q      <= 1'b1;
      rnw_mac_q  <= 1'b1;
      abe_q      <= 1'b0;
      dbe_q      <= 1'b0;
      dlatch_q   <= 1'b0;
      ready_q    <= 1'b0;
      berr_mac_q <= 1'b1;
    end else begin
      c8m_q      <= {c8m_q[1:0], C8M};
      e_q        <= {e_q[1:0], E};
      dtack_q    <= {dtack_q[0], nDTACKIn};
      vpa_q      <= {vpa_q[0], nVPAIn};
      berr_q     <= {berr_q[0], nBERRIn};
      state_q    <= state_d;
      vsub_q     <= vsub_d;
      cnt_q      <= cnt_d;
      rnw_lat_q  <= rnw_lat_d;
      uds_lat_q  <= uds_lat_d;
      lds_lat_q  <= lds_lat_d;
      err_q      <= err_d;
      as_q       <= as_d;
      uds_q      <= uds_d;
      lds_q      <= lds_d;
      vma_q      <= vma_d;
      rnw_mac_q  <= rnw_mac_d;
      abe_q      <= abe_d;
      dbe_q      <= dbe_d;
      dlatch_q   <= dlatch_d;
      ready_q    <= ready_d;
      berr_mac_q <= berr_mac_d;
    end
  end

  assign nASMac   = as_q;
  assign nUDSMac  = uds_q;
  assign nLDSMac  = lds_q;
  assign nVMA     = vma_q;
  assign RnWMac   = rnw_mac_q;
  assign ABEn     = abe_q;
  assign DBEn     = dbe_q;
  assign DLatch   = dlatch_q;
  assign Ready    = ready_q;
  assign nBERRMac = berr_mac_q;

endmodule
